uart_frame_receiver: RTL and testbench

Frame-level controller that sits behind the UART byte receiver. It sequences the received byte stream through a sync/length/payload/checksum protocol and buffers the payload. It releases a frame downstream over a valid/ready stream only after the checksum has verified. It also reports framing errors, inter-byte timeouts and overruns.

---
 rtl/uart_frame_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_receiver.sv
// Frame-level receiver behind a UART byte receiver: SYNC / LEN / payload / checksum,
// buffers the payload and releases it on a valid/ready stream once the checksum verifies.
module uart_frame_receiver #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 10000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       RxDone_i,
  input  logic [7:0] RxData_i,
  output logic       Valid_o,
  output logic [7:0] Data_o,
  output logic       Last_o,
  input  logic       Ready_i,
  output logic       FrameOk_o,
  output logic       Error_o,
  output logic [2:0] ErrorCode_o,
  output logic       Busy_o
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, LENGTH, PAYLOAD, CHECKSUM, DRAIN} state_t;
  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_BAD_LEN      = 3'd1,
    ERR_BAD_CHECKSUM = 3'd2,
    ERR_TIMEOUT      = 3'd3,
    ERR_OVERRUN      = 3'd4
  } err_t;

  state_t           state, next_state;
  err_t             err_code, err_q;
  logic             err_set, ok_set;
  logic [7:0]       len_q, sum_q;
  logic [IDX_W-1:0] wr_idx, rd_idx, rd_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       mem [MAX_LEN];
  logic             active, timed_out, xfer;

  assign active      = (state == LENGTH) || (state == PAYLOAD) || (state == CHECKSUM);
  assign timed_out   = active && !RxDone_i && (tmo_cnt == TMO_LAST);
  assign xfer        = Valid_o && Ready_i;
  assign rd_next     = rd_idx + 1'b1;
  assign ErrorCode_o = err_q;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    err_code   = ERR_NONE;
    ok_set     = 1'b0;
    case (state)
      IDLE: if (RxDone_i && RxData_i == SYNC_BYTE) next_state = LENGTH;
      LENGTH: begin
        if (RxDone_i) begin
          if (RxData_i > 8'(MAX_LEN)) begin
            err_set    = 1'b1;
            err_code   = ERR_BAD_LEN;
            next_state = IDLE;
          end else if (RxData_i == 8'd0) begin
            next_state = CHECKSUM;
          end else begin
            next_state = PAYLOAD;
          end
        end
      end
      PAYLOAD: if (RxDone_i && 8'(wr_idx) == len_q - 8'd1) next_state = CHECKSUM;
      CHECKSUM: begin
        if (RxDone_i) begin
          if (RxData_i == sum_q) begin
            ok_set     = 1'b1;
            next_state = (len_q == 8'd0) ? IDLE : DRAIN;
          end else begin
            err_set    = 1'b1;
            err_code   = ERR_BAD_CHECKSUM;
            next_state = IDLE;
          end
        end
      end
      DRAIN: begin
        // bytes arriving while draining are dropped and flagged; draining is unaffected
        if (RxDone_i) begin
          err_set  = 1'b1;
          err_code = ERR_OVERRUN;
        end
        if (xfer && Last_o) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // timed_out already excludes a byte on the expiry cycle, so the byte wins
    if (timed_out) begin
      err_set    = 1'b1;
      err_code   = ERR_TIMEOUT;
      next_state = IDLE;
    end
  end

  always_ff @(posedge Clock) begin
    if (state == PAYLOAD && RxDone_i) mem[wr_idx] <= RxData_i;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      len_q     <= '0;
      sum_q     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      tmo_cnt   <= '0;
      Valid_o   <= 1'b0;
      Data_o    <= '0;
      Last_o    <= 1'b0;
      FrameOk_o <= 1'b0;
      Error_o   <= 1'b0;
      err_q     <= ERR_NONE;
      Busy_o    <= 1'b0;
    end else begin
      FrameOk_o <= ok_set;
      Error_o   <= err_set;
      if (err_set) err_q <= err_code;
      Busy_o    <= (next_state != IDLE);
      tmo_cnt   <= (RxDone_i || !active) ? '0 : tmo_cnt + 1'b1;

      if (RxDone_i && state == LENGTH) begin
        len_q  <= RxData_i;
        sum_q  <= RxData_i;
        wr_idx <= '0;
      end
      if (RxDone_i && state == PAYLOAD) begin
        sum_q  <= sum_q + RxData_i;
        wr_idx <= wr_idx + 1'b1;
      end

      // Data_o/Last_o are preloaded from the buffer so the stream outputs stay registered
      if (state == CHECKSUM && next_state == DRAIN) begin
        Valid_o <= 1'b1;
        Data_o  <= mem[0];
        Last_o  <= (len_q == 8'd1);
        rd_idx  <= '0;
      end else if (xfer) begin
        if (Last_o) begin
          Valid_o <= 1'b0;
          Last_o  <= 1'b0;
        end else begin
          Data_o  <= mem[rd_next];
          Last_o  <= (8'(rd_next) == len_q - 8'd1);
          rd_idx  <= rd_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver: scoreboard of expected payload bytes,
// pulse/code checks at known cycles.
module tb_uart_frame_receiver;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       RxDone_i = 1'b0;
  logic [7:0] RxData_i = '0;
  logic       Ready_i = 1'b1;
  logic       Valid_o, Last_o, FrameOk_o, Error_o, Busy_o;
  logic [7:0] Data_o;
  logic [2:0] ErrorCode_o;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic [8:0] sb[$];
  logic [7:0] pl[$];

  always #5 Clock = ~Clock;

  uart_frame_receiver #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN(16),
    .TIMEOUT_TICKS(100)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .RxDone_i(RxDone_i),
    .RxData_i(RxData_i),
    .Valid_o(Valid_o),
    .Data_o(Data_o),
    .Last_o(Last_o),
    .Ready_i(Ready_i),
    .FrameOk_o(FrameOk_o),
    .Error_o(Error_o),
    .ErrorCode_o(ErrorCode_o),
    .Busy_o(Busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RxDone_i = 1'b1;
    RxData_i = b;
    tick();
    RxDone_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p[$], input bit corrupt);
    logic [7:0] sum;
    logic       lst;
    sum = 8'(p.size());
    send_byte(8'hA5);
    send_byte(8'(p.size()));
    foreach (p[i]) begin
      sum = sum + p[i];
      lst = (i == p.size() - 1);
      if (!corrupt) sb.push_back({lst, p[i]});
      send_byte(p[i]);
    end
    send_byte(corrupt ? sum - 8'd1 : sum);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && !(sb.size() == 0 && !Valid_o); i++) tick();
    check(tag, {31'd0, (sb.size() == 0 && !Valid_o)}, 32'd1);
  endtask

  // Stream monitor: every accepted byte must match the next scoreboard entry
  always @(negedge Clock) begin
    logic [8:0] exp;
    if (Error_o === 1'b1) err_pulses++;
    if (!Reset && Valid_o === 1'b1 && Ready_i) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 9'h1FF;
      check("stream_byte", {23'd0, Last_o, Data_o}, {23'd0, exp});
    end
  end

  initial begin
    // reset
    tick(); tick();
    Reset = 1'b0;
    check("rst_valid", Valid_o, 0);
    check("rst_data", Data_o, 0);
    check("rst_last", Last_o, 0);
    check("rst_ok", FrameOk_o, 0);
    check("rst_err", Error_o, 0);
    check("rst_code", ErrorCode_o, 0);
    check("rst_busy", Busy_o, 0);

    // good frame
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 1'b0);
    check("good_ok", FrameOk_o, 1);
    check("good_valid", Valid_o, 1);
    check("good_err", Error_o, 0);
    tick();
    check("good_ok_pulse", FrameOk_o, 0);
    wait_drain("good_drain");
    check("good_busy_after", Busy_o, 0);
    check("good_no_err", err_pulses, 0);

    // bad checksum, then a good single-byte frame
    send_frame(pl, 1'b1);
    check("badck_err", Error_o, 1);
    check("badck_code", ErrorCode_o, 2);
    check("badck_valid", Valid_o, 0);
    check("badck_busy", Busy_o, 0);
    pl = '{8'h7F};
    send_frame(pl, 1'b0);
    check("after_badck_ok", FrameOk_o, 1);
    check("code_held", ErrorCode_o, 2);
    wait_drain("after_badck_drain");

    // length too large
    send_byte(8'hA5);
    send_byte(8'h20);
    check("badlen_err", Error_o, 1);
    check("badlen_code", ErrorCode_o, 1);
    check("badlen_busy", Busy_o, 0);

    // leading garbage then zero-length frame
    send_byte(8'h00);
    check("garbage0_busy", Busy_o, 0);
    send_byte(8'hFF);
    check("garbage1_busy", Busy_o, 0);
    send_byte(8'hA5);
    check("sync_busy", Busy_o, 1);
    send_byte(8'h00);
    send_byte(8'h00);
    check("len0_ok", FrameOk_o, 1);
    check("len0_valid", Valid_o, 0);
    check("len0_busy", Busy_o, 0);
    tick();
    check("len0_valid_later", Valid_o, 0);

    // timeout: error exactly 100 cycles after the last byte
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (99) tick();
    check("tmo_not_yet_err", Error_o, 0);
    check("tmo_not_yet_busy", Busy_o, 1);
    tick();
    check("tmo_err", Error_o, 1);
    check("tmo_code", ErrorCode_o, 3);
    check("tmo_busy", Busy_o, 0);

    // byte on the expiry cycle wins
    send_byte(8'hA5);
    send_byte(8'h02);
    sb.push_back({1'b0, 8'h11});
    send_byte(8'h11);
    repeat (99) tick();
    sb.push_back({1'b1, 8'h22});
    send_byte(8'h22);
    check("tmo_race_err", Error_o, 0);
    check("tmo_race_busy", Busy_o, 1);
    send_byte(8'h35);
    check("tmo_race_ok", FrameOk_o, 1);
    check("tmo_race_code", ErrorCode_o, 3);
    wait_drain("tmo_race_drain");

    // backpressure with overrun during drain
    Ready_i = 1'b0;
    pl = '{8'hAA, 8'hBB};
    send_frame(pl, 1'b0);
    check("bp_ok", FrameOk_o, 1);
    check("bp_valid", Valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        send_byte(8'h5A);
        check("ovr_err", Error_o, 1);
        check("ovr_code", ErrorCode_o, 4);
      end else begin
        tick();
      end
      check("bp_stable_data", Data_o, 8'hAA);
      check("bp_stable_valid", Valid_o, 1);
    end
    Ready_i = 1'b1;
    wait_drain("bp_drain");

    // reset mid-payload discards the frame
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    send_byte(8'h02);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_valid", Valid_o, 0);
    check("mid_rst_err", Error_o, 0);
    check("mid_rst_code", ErrorCode_o, 0);
    check("mid_rst_busy", Busy_o, 0);
    pl = '{8'h10, 8'h20};
    send_frame(pl, 1'b0);
    check("post_rst_ok", FrameOk_o, 1);
    wait_drain("post_rst_drain");

    check("sb_empty", sb.size(), 0);
    check("err_pulse_count", err_pulses, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
